// File: rtl/afe_pkg.sv
// afe_pkg: shared controller state encoding, default channel count and sticky error bit indices
package afe_pkg;
  typedef enum logic [2:0] {S_IDLE, S_ARMED, S_SETTLE, S_CONV, S_WAIT_STO} state_e;
  localparam int CH_NUM_DEF  = 64;
  localparam int ERR_W       = 3;
  localparam int ERR_OVF_BIT = 0;
  localparam int ERR_CNT_BIT = 1;
  localparam int ERR_TMO_BIT = 2;
endpackage

// File: rtl/afe_line_capture_if.sv
// afe_line_capture_if: AFE tokens/clock, ADC handshake, pixel stream (PIX_*), LINE_CNT and sticky ERR_* flags; slave = capture block, master = environment
interface afe_line_capture_if;
  logic        AFE_CLK, AFE_STI, AFE_STO;
  logic        ADC_CONV, ADC_VALID;
  logic [15:0] ADC_DATA;
  logic [15:0] PIX_DATA;
  logic [5:0]  PIX_CH;
  logic        PIX_SOL, PIX_EOL, PIX_VALID, PIX_READY;
  logic [15:0] LINE_CNT;
  logic        ERR_OVF, ERR_CNT, ERR_TMO, ERR_CLR;
  modport slave (
    input  AFE_CLK, AFE_STI, AFE_STO, ADC_DATA, ADC_VALID, PIX_READY, ERR_CLR,
    output ADC_CONV, PIX_DATA, PIX_CH, PIX_SOL, PIX_EOL, PIX_VALID, LINE_CNT, ERR_OVF, ERR_CNT, ERR_TMO
  );
  modport master (
    output AFE_CLK, AFE_STI, AFE_STO, ADC_DATA, ADC_VALID, PIX_READY, ERR_CLR,
    input  ADC_CONV, PIX_DATA, PIX_CH, PIX_SOL, PIX_EOL, PIX_VALID, LINE_CNT, ERR_OVF, ERR_CNT, ERR_TMO
  );
endinterface

// File: rtl/afe_edge_det.sv
// afe_edge_det: rising-edge detector (clk, rst in; d in; rise out = d high while its one-cycle copy is low)
module afe_edge_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);
  logic d_q;
  always_ff @(posedge clk) d_q <= rst ? 1'b0 : d;
  assign rise = d & ~d_q;
endmodule

// File: rtl/afe_line_capture.sv
// afe_line_capture: AFE line readout controller (CLK_100M, CLK_RST; bus = AFE tokens, ADC conversion handshake, pixel stream, line count, sticky errors)
module afe_line_capture
  import afe_pkg::*;
#(
  parameter int CH_NUM    = CH_NUM_DEF,
  parameter int T_SETTLE  = 20,
  parameter int T_ADC_TMO = 60
) (
  input logic               CLK_100M,
  input logic               CLK_RST,
  afe_line_capture_if.slave bus
);
  localparam int CW = $clog2(CH_NUM + 1);
  localparam int TW = 16;
  state_e            state_q, state_d;
  logic [CW-1:0]     ch_q, ch_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic              conv_q, conv_d, pv_q, pv_d, sol_q, sol_d, eol_q, eol_d;
  logic [15:0]       data_q, data_d, line_q, line_d;
  logic [5:0]        pch_q, pch_d;
  logic [ERR_W-1:0]  err_q, err_d, err_set;
  logic              clk_rise, sti_rise, sto_rise, tmo;
  afe_edge_det u_clk (.clk(CLK_100M), .rst(CLK_RST), .d(bus.AFE_CLK), .rise(clk_rise));
  afe_edge_det u_sti (.clk(CLK_100M), .rst(CLK_RST), .d(bus.AFE_STI), .rise(sti_rise));
  afe_edge_det u_sto (.clk(CLK_100M), .rst(CLK_RST), .d(bus.AFE_STO), .rise(sto_rise));
  always_comb begin
    state_d = state_q;
    ch_d    = ch_q;
    tmr_d   = tmr_q + TW'(1);
    conv_d  = 1'b0;
    data_d  = data_q;
    pch_d   = pch_q;
    sol_d   = sol_q;
    eol_d   = eol_q;
    pv_d    = pv_q & ~bus.PIX_READY;
    line_d  = line_q;
    err_set = '0;
    tmo     = tmr_q >= TW'(T_ADC_TMO - 1);
    // a restart token outranks everything else, then an end token
    if (sti_rise) begin
      state_d = S_ARMED;
      ch_d    = '0;
      err_set[ERR_CNT_BIT] = state_q != S_IDLE;
    end else if (sto_rise && state_q != S_IDLE) begin
      state_d = S_IDLE;
      if (state_q == S_WAIT_STO) line_d = line_q + 16'd1;
      else err_set[ERR_CNT_BIT] = 1'b1;
    end else begin
      case (state_q)
        S_ARMED:
          if (clk_rise && ch_q < CW'(CH_NUM)) begin
            state_d = S_SETTLE;
            tmr_d   = TW'(1);
          end
        S_SETTLE: begin
          err_set[ERR_CNT_BIT] = clk_rise;
          if (tmr_q >= TW'(T_SETTLE - 1)) begin
            state_d = S_CONV;
            tmr_d   = '0;
            conv_d  = 1'b1;
          end
        end
        S_CONV: begin
          err_set[ERR_CNT_BIT] = clk_rise;
          if (bus.ADC_VALID) begin
            data_d = bus.ADC_DATA;
            pch_d  = 6'(ch_q);
            sol_d  = ch_q == '0;
            eol_d  = ch_q == CW'(CH_NUM - 1);
            pv_d   = 1'b1;
            err_set[ERR_OVF_BIT] = pv_q & ~bus.PIX_READY;
          end else err_set[ERR_TMO_BIT] = tmo;
          // a timed-out channel is skipped but still consumes its index
          if (bus.ADC_VALID || tmo) begin
            ch_d    = ch_q + CW'(1);
            state_d = ch_q == CW'(CH_NUM - 1) ? S_WAIT_STO : S_ARMED;
          end
        end
        S_WAIT_STO: err_set[ERR_CNT_BIT] = clk_rise;
        default: ;
      endcase
    end
    err_d = (err_q & ~{ERR_W{bus.ERR_CLR}}) | err_set;
  end
  always_ff @(posedge CLK_100M) begin
    if (CLK_RST) begin
      state_q <= S_IDLE;
      ch_q    <= '0;
      tmr_q   <= '0;
      conv_q  <= 1'b0;
      data_q  <= '0;
      pch_q   <= '0;
      sol_q   <= 1'b0;
      eol_q   <= 1'b0;
      pv_q    <= 1'b0;
      line_q  <= '0;
      err_q   <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
      tmr_q   <= tmr_d;
      conv_q  <= conv_d;
      data_q  <= data_d;
      pch_q   <= pch_d;
      sol_q   <= sol_d;
      eol_q   <= eol_d;
      pv_q    <= pv_d;
      line_q  <= line_d;
      err_q   <= err_d;
    end
  end
  assign bus.ADC_CONV  = conv_q;
  assign bus.PIX_DATA  = data_q;
  assign bus.PIX_CH    = pch_q;
  assign bus.PIX_SOL   = sol_q;
  assign bus.PIX_EOL   = eol_q;
  assign bus.PIX_VALID = pv_q;
  assign bus.LINE_CNT  = line_q;
  assign bus.ERR_OVF   = err_q[ERR_OVF_BIT];
  assign bus.ERR_CNT   = err_q[ERR_CNT_BIT];
  assign bus.ERR_TMO   = err_q[ERR_TMO_BIT];
endmodule

// File: tb/tb_afe_line_capture.sv
// tb_afe_line_capture: randomized scoreboard bench for afe_line_capture
module tb_afe_line_capture;
  typedef struct {logic [15:0] d; int ch; bit sol; bit eol;} pix_t;
  logic clk = 1'b0;
  logic rst;
  afe_line_capture_if bus();
  afe_line_capture dut (.CLK_100M(clk), .CLK_RST(rst), .bus(bus));
  always #5 clk = ~clk;
  int checks = 0;
  int errors = 0;
  pix_t exp_q[$];
  int conv_idx = 0;
  int conv_total = 0;
  int silent_ch = -1;
  bit tmo_check = 0;
  bit nominal = 1;
  bit stall = 0;
  int ready_mode = 0;
  int line_exp = 0;
  logic [15:0] last_data = '0;
  task automatic chk(input string n, input logic [31:0] got, input logic [31:0] exp_v);
    checks++;
    if (got !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h required %h", n, got, exp_v);
    end
  endtask
  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask
  task automatic ch_pulse();
    bus.AFE_CLK = 1'b1;
    cyc(65);
    bus.AFE_CLK = 1'b0;
    cyc(65);
  endtask
  task automatic chans(input int n);
    for (int i = 0; i < n; i++) ch_pulse();
  endtask
  task automatic sti();
    conv_idx = 0;
    bus.AFE_STI = 1'b1;
    cyc(2);
    bus.AFE_STI = 1'b0;
    cyc(5);
  endtask
  task automatic sto();
    bus.AFE_STO = 1'b1;
    cyc(2);
    bus.AFE_STO = 1'b0;
    cyc(5);
  endtask
  task automatic flags(input string tag, input bit o, input bit c, input bit t);
    @(negedge clk);
    chk({tag, "_ovf"}, 32'(bus.ERR_OVF), 32'(o));
    chk({tag, "_cnt"}, 32'(bus.ERR_CNT), 32'(c));
    chk({tag, "_tmo"}, 32'(bus.ERR_TMO), 32'(t));
    chk({tag, "_line"}, 32'(bus.LINE_CNT), 32'(line_exp));
    cyc(1);
  endtask
  task automatic clr();
    bus.ERR_CLR = 1'b1;
    cyc(1);
    bus.ERR_CLR = 1'b0;
    cyc(1);
    flags("clr", 0, 0, 0);
  endtask
  task automatic rst_chk(input string tag);
    chk({tag, "_ctl"}, 32'({bus.PIX_VALID, bus.PIX_SOL, bus.PIX_EOL, bus.ADC_CONV,
                            bus.ERR_OVF, bus.ERR_CNT, bus.ERR_TMO, bus.PIX_CH}), 32'd0);
    chk({tag, "_data"}, 32'(bus.PIX_DATA), 32'd0);
    chk({tag, "_line"}, 32'(bus.LINE_CNT), 32'd0);
  endtask
  // downstream acceptance: random, stalled, or always ready
  initial forever begin
    @(posedge clk);
    #1;
    bus.PIX_READY = ready_mode == 0 ? 1'($urandom_range(0, 1)) : ready_mode == 2;
  end
  // ADC model: the k-th conversion after a start token belongs to channel k
  initial begin
    int ch, dl, k;
    logic [15:0] d;
    bus.ADC_VALID = 1'b0;
    bus.ADC_DATA = '0;
    forever begin
      @(negedge clk);
      if (bus.ADC_CONV) begin
        conv_total++;
        ch = conv_idx;
        conv_idx++;
        if (ch == silent_ch) begin
          if (tmo_check) begin
            for (k = 1; k <= 80; k++) begin
              @(negedge clk);
              if (bus.ERR_TMO) break;
            end
            chk("tmo_latency", 32'(k), 32'd60);
          end
        end else begin
          d = nominal ? 16'(ch * 16'h0101) : 16'($urandom);
          dl = nominal ? 10 : $urandom_range(1, 50);
          repeat (dl) @(posedge clk);
          #1;
          bus.ADC_DATA = d;
          bus.ADC_VALID = 1'b1;
          last_data = d;
          // a stalled consumer loses the unaccepted sample to the newer one
          if (stall && exp_q.size() > 0) void'(exp_q.pop_back());
          exp_q.push_back('{d: d, ch: ch, sol: ch == 0, eol: ch == 63});
          @(posedge clk);
          #1;
          bus.ADC_VALID = 1'b0;
          @(negedge clk);
          chk("cap_valid", 32'(bus.PIX_VALID), 32'd1);
          chk("cap_data", 32'(bus.PIX_DATA), 32'(d));
        end
      end
    end
  end
  // monitor: every accepted pixel must be the oldest outstanding expectation
  initial begin
    pix_t e;
    forever begin
      @(negedge clk);
      if (bus.PIX_VALID && bus.PIX_READY) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL pix_unexpected: got ch %0d data %h, required no pixel", bus.PIX_CH, bus.PIX_DATA);
        end else begin
          e = exp_q.pop_front();
          chk("pix_data", 32'(bus.PIX_DATA), 32'(e.d));
          chk("pix_ch", 32'(bus.PIX_CH), 32'(e.ch));
          chk("pix_sol", 32'(bus.PIX_SOL), 32'(e.sol));
          chk("pix_eol", 32'(bus.PIX_EOL), 32'(e.eol));
        end
      end
    end
  end
  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1, "watchdog");
  end
  initial begin
    int c0;
    rst = 1'b1;
    bus.AFE_CLK = 1'b0;
    bus.AFE_STI = 1'b0;
    bus.AFE_STO = 1'b0;
    bus.ERR_CLR = 1'b0;
    cyc(3);
    @(negedge clk);
    rst_chk("reset");
    cyc(1);
    rst = 1'b0;
    cyc(3);
    // nominal line
    sti();
    chans(64);
    sto();
    line_exp = 1;
    flags("nominal", 0, 0, 0);
    // backpressure across two samples
    nominal = 0;
    sti();
    ready_mode = 1;
    stall = 1;
    chans(2);
    @(negedge clk);
    chk("bp_ovf", 32'(bus.ERR_OVF), 32'd1);
    chk("bp_data", 32'(bus.PIX_DATA), 32'(last_data));
    chk("bp_valid", 32'(bus.PIX_VALID), 32'd1);
    cyc(1);
    stall = 0;
    ready_mode = 0;
    chans(62);
    sto();
    line_exp = 2;
    flags("bp", 1, 0, 0);
    clr();
    // short line, then confirm the controller sits idle
    sti();
    chans(40);
    sto();
    flags("short", 0, 1, 0);
    c0 = conv_total;
    ch_pulse();
    chk("short_idle", 32'(conv_total), 32'(c0));
    clr();
    // silent ADC on channel 5
    silent_ch = 5;
    tmo_check = 1;
    sti();
    chans(64);
    sto();
    line_exp = 3;
    flags("tmo", 0, 0, 1);
    silent_ch = -1;
    tmo_check = 0;
    clr();
    // start token re-pulsed at channel 30
    sti();
    chans(30);
    sti();
    chans(64);
    sto();
    line_exp = 4;
    flags("restart", 0, 1, 0);
    clr();
    // random lines, the second with an extra channel clock
    sti();
    chans(64);
    sto();
    line_exp = 5;
    flags("rand0", 0, 0, 0);
    sti();
    chans(64);
    ch_pulse();
    sto();
    line_exp = 6;
    flags("rand1", 0, 1, 0);
    clr();
    // reset while converting channel 12
    ready_mode = 2;
    sti();
    chans(12);
    silent_ch = 12;
    bus.AFE_CLK = 1'b1;
    cyc(25);
    chk("rst_in_conv", 32'(conv_idx), 32'd13);
    rst = 1'b1;
    cyc(1);
    rst = 1'b0;
    @(negedge clk);
    rst_chk("midrst");
    exp_q.delete();
    line_exp = 0;
    cyc(1);
    bus.AFE_CLK = 1'b0;
    cyc(65);
    silent_ch = -1;
    ready_mode = 0;
    sti();
    chans(64);
    sto();
    line_exp = 1;
    flags("post_rst", 0, 0, 0);
    cyc(50);
    chk("drain", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/afe_line_capture.md
AFE_LINE_CAPTURE -- requirements
Module: afe_line_capture

Interface
REQ-001 SHALL have parameter CH_NUM, default 64: analog channels per AFE readout line.
REQ-002 SHALL have parameter T_SETTLE, default 20: CLK_100M cycles from AFE_CLK rising edge to ADC_CONV.
REQ-003 SHALL have parameter T_ADC_TMO, default 60: maximum CLK_100M cycles from ADC_CONV to ADC_VALID.
REQ-004 CLK_100M  in  1  system clock; all AFE_* inputs are registered in this domain, so no synchroniser is needed.
REQ-005 CLK_RST  in  1  reset; one clock; reset is synchronous and active-high.
REQ-006 AFE_CLK  in  1  AFE shift clock; one channel is presented on each rising edge.
REQ-007 AFE_STI  in  1  start-of-readout token driven to the AFE.
REQ-008 AFE_STO  in  1  end-of-readout token returned by the AFE.
REQ-009 ADC_CONV  out  1  one-cycle conversion-start pulse to the ADS front end.
REQ-010 ADC_DATA  in  16  conversion result.
REQ-011 ADC_VALID  in  1  one-cycle qualifier for ADC_DATA.
REQ-012 PIX_DATA  out  16  captured sample.
REQ-013 PIX_CH  out  6  channel index of PIX_DATA.
REQ-014 PIX_SOL / PIX_EOL  out  1 each  first-channel / last-channel flags.
REQ-015 PIX_VALID  out  1  output qualifier.
REQ-016 PIX_READY  in  1  downstream accept.
REQ-017 LINE_CNT  out  16  count of completed good lines.
REQ-018 ERR_OVF, ERR_CNT, ERR_TMO  out  1 each  sticky error flags.
REQ-019 ERR_CLR  in  1  clears all three sticky error flags.

Function
REQ-020 SHALL detect rising edges of AFE_CLK, AFE_STI and AFE_STO by comparing each input with a one-cycle registered copy.
REQ-021 SHALL implement the states IDLE, ARMED, SETTLE, CONV and WAIT_STO.
  - IDLE -> ARMED on AFE_STI rise; ch_cnt <= 0.
  - ARMED -> SETTLE on AFE_CLK rise while ch_cnt < CH_NUM.
  - SETTLE -> CONV after T_SETTLE cycles, with ADC_CONV pulsed in the transition cycle.
REQ-022 In CONV, on ADC_VALID, SHALL load the output register with ADC_DATA, PIX_CH=ch_cnt, PIX_SOL=(ch_cnt==0) and PIX_EOL=(ch_cnt==CH_NUM-1), and SHALL then increment ch_cnt.
  - Next state is WAIT_STO if ch_cnt reaches CH_NUM, else ARMED.
REQ-023 Capture latency SHALL be one cycle from ADC_VALID to PIX_VALID=1.
REQ-024 PIX_VALID SHALL hold, with stable data, until the cycle in which PIX_VALID and PIX_READY are both 1.
REQ-025 If ADC_VALID arrives while the output register is still unaccepted, SHALL overwrite the register and set ERR_OVF.
REQ-026 In WAIT_STO, an AFE_STO rise SHALL increment LINE_CNT (wrapping 0xFFFF->0) and go to IDLE.
REQ-027 In WAIT_STO, an AFE_CLK rise (extra channel) SHALL set ERR_CNT and be ignored.
REQ-028 An AFE_STO rise in ARMED, SETTLE or CONV (short line) SHALL set ERR_CNT and go to IDLE without incrementing LINE_CNT.
REQ-029 An AFE_STI rise in any non-IDLE state SHALL set ERR_CNT and restart in ARMED with ch_cnt=0.
REQ-030 If ADC_VALID is absent T_ADC_TMO cycles after ADC_CONV, SHALL set ERR_TMO, skip that channel (ch_cnt still increments) and proceed as in REQ-022.
REQ-031 An AFE_CLK rise during SETTLE or CONV SHALL set ERR_CNT and be otherwise ignored.
REQ-032 ADC_VALID outside CONV SHALL be ignored.
REQ-033 If ERR_CLR and an error-setting event occur in the same cycle, the set SHALL win.
REQ-034 A restart event (REQ-029) SHALL take priority over REQ-026 to REQ-028 in the same cycle.

Reset
REQ-035 On CLK_RST=1 at a clock edge, SHALL force:
  - state IDLE;
  - ch_cnt, timers, LINE_CNT, PIX_* and ADC_CONV to 0;
  - all error flags to 0;
  - edge-detect registers to 0.
REQ-036 Reset mid-line SHALL discard any pending pixel; no partial line is counted.

Structure
REQ-037 The state encoding, CH_NUM default and error-bit indices SHALL live in shared package afe_pkg, which the AFE controller also uses.
REQ-038 Edge detection SHALL be one sub-module, afe_edge_det, instantiated three times.

Verification
REQ-039 Nominal line: STI pulse, then 64 AFE_CLK rises at 1300 ns period, ADC answers 10 cycles after CONV with data=ch*0x101, then STO -> 64 pixels with SOL on ch0 and EOL on ch63, LINE_CNT=1, no errors.
REQ-040 Backpressure: hold PIX_READY=0 across two ADC_VALIDs -> ERR_OVF=1 and PIX_DATA equals the second sample.
REQ-041 Short line: STO after 40 channels -> ERR_CNT=1, LINE_CNT unchanged, state IDLE.
REQ-042 ADC silent on ch5 -> ERR_TMO=1 exactly 60 cycles after CONV; the next pixel has PIX_CH=6.
REQ-043 STI re-pulsed at ch30 -> ERR_CNT=1; the following pixel has PIX_CH=0 and SOL=1.
REQ-044 CLK_RST asserted in CONV at ch12 -> all outputs 0 on the next cycle; a clean line afterwards gives LINE_CNT=1.
